// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
//   chunk_width() : bits handled by each pipeline stage (WIDTH / STAGES).
//   stage_ctl_t   : per-stage control bits. The top wraps these with the
//                   WIDTH-dependent operand and partial-sum fields.
//                   A package cannot hold a WIDTH-parametrised type.
package adder_pkg;

  function automatic int unsigned chunk_width(input int unsigned width,
                                              input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

  typedef struct packed {
    logic valid;  // stage holds a live operand set
    logic carry;  // carry out of the chunk this stage summed
    logic ovf;    // carry-into-MSB ^ carry-out; only meaningful in the last stage
    logic sub;    // operand set is a subtraction (b inverted)
  } stage_ctl_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational ripple-carry slice used by every pipeline stage.
// Ports:
//   i_a, i_b  WIDTH-bit addends (b already inverted for subtraction)
//   i_cin     carry into bit 0
//   o_s       WIDTH-bit sum
//   o_cout    carry out of the slice MSB
//   o_cmsb    carry into the slice MSB (feeds signed-overflow detection)
module rca_chunk #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_s,
  output logic             o_cout,
  output logic             o_cmsb
);

  always_comb begin
    logic w_carry;
    w_carry = i_cin;
    o_cmsb  = i_cin;
    o_s     = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      o_cmsb  = w_carry;  // last iteration leaves the carry into the MSB
      o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder. WIDTH-bit operands are split into STAGES
// chunks; each stage ripples one chunk and registers its carry onward.
// Results appear STAGES-1 edges after the accepting edge; throughput is one
// operand set per cycle with valid/ready on both sides.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_valid/ready  operand handshake (in_ready = !out_valid || out_ready)
//   a, b, c_in      operands and carry in
//   sub             (PIPELINED_RCA_SUB_EN only) compute a + ~b + c_in
//   out_valid/ready result handshake
//   sum, c_out      registered result and true carry out of the MSB
//   overflow        two's-complement overflow (carry into MSB ^ c_out)
// Optional feature macro: PIPELINED_RCA_SUB_EN
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPELINED_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned Chunk = chunk_width(WIDTH, STAGES);

  if (STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_rca_adder: STAGES must be 1..WIDTH and divide WIDTH");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] a;  // operands travel forward for the chunks still to sum
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;  // chunks summed so far; upper bits are filled later
  } stage_t;

  stage_t r_stage [STAGES];
  stage_t w_next  [STAGES];
  logic   w_adv;
  logic   w_sub_in;

`ifdef PIPELINED_RCA_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign w_adv    = !r_stage[STAGES-1].ctl.valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_s_prev;
    logic [WIDTH-1:0] w_s_new;
    logic [Chunk-1:0] w_chunk_s;
    logic             w_valid;
    logic             w_cin;
    logic             w_sub;
    logic             w_cout;
    logic             w_cmsb;

    if (k == 0) begin : g_head
      assign w_a      = a;
      assign w_b      = b;
      assign w_s_prev = '0;
      assign w_valid  = in_valid;
      assign w_cin    = c_in;
      assign w_sub    = w_sub_in;
    end else begin : g_body
      assign w_a      = r_stage[k-1].a;
      assign w_b      = r_stage[k-1].b;
      assign w_s_prev = r_stage[k-1].s;
      assign w_valid  = r_stage[k-1].ctl.valid;
      assign w_cin    = r_stage[k-1].ctl.carry;
      assign w_sub    = r_stage[k-1].ctl.sub;
    end

    rca_chunk #(
      .WIDTH (Chunk)
    ) u_chunk (
      .i_a    (w_a[k*Chunk +: Chunk]),
      .i_b    (w_b[k*Chunk +: Chunk] ^ {Chunk{w_sub}}),
      .i_cin  (w_cin),
      .o_s    (w_chunk_s),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
    );

    always_comb begin
      w_s_new                    = w_s_prev;
      w_s_new[k*Chunk +: Chunk] = w_chunk_s;
    end

    assign w_next[k] = '{ctl: '{valid: w_valid, carry: w_cout, ovf: w_cmsb ^ w_cout,
                                sub: w_sub},
                         a: w_a, b: w_b, s: w_s_new};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        r_stage[k] <= w_next[k];
      end
    end
  end

  assign out_valid = r_stage[STAGES-1].ctl.valid;
  assign sum       = r_stage[STAGES-1].s;
  assign c_out     = r_stage[STAGES-1].ctl.carry;
  assign overflow  = r_stage[STAGES-1].ctl.ovf;

endmodule
